alu_issue_sched: RTL and testbench

Issue scheduler for the execute-stage ALU.
- Single-cycle ops (ADD/SUB/AND/OR) and the pipelined MUL path share one writeback port into the ALU output register.
- The block decides each cycle whether the op in E may issue, tracks in-flight results, and drives writeback tag/select signals.
- Provides RAW-hazard lookup for decode.
- Sits between the decode/hazard unit and the ALU + writeback mux.

---
 rtl/alu_issue_sched_pkg.sv | 25 ++
 rtl/alu_issue_sched_if.sv | 31 +++
 rtl/alu_issue_sched_wb_claim_shifter.sv | 55 +++++
 rtl/alu_issue_sched.sv | 116 +++++++++++
 tb/tb_alu_issue_sched.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_sched_pkg.sv
// Shared opcode encoding and defaults for the ALU issue scheduler.
package alu_issue_sched_pkg;

  localparam int FUNCT3_W        = 3;
  localparam int DEFAULT_MUL_LAT = 4;
  localparam int DEFAULT_REG_W   = 5;

  // funct3 codes as driven on ALUControlE
  typedef enum logic [FUNCT3_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_MUL = 3'b100
  } aluOpE;

  localparam logic [FUNCT3_W-1:0] MUL_FUNCT3 = OP_MUL;

  // Writeback latency of an op; anything that is not MUL (including
  // undefined codes) is treated as a single-cycle ALU op.
  function automatic int opLatency(input logic [FUNCT3_W-1:0] op, input int mulLat);
    return (op == MUL_FUNCT3) ? mulLat : 1;
  endfunction

endpackage

// File: rtl/alu_issue_sched_if.sv
// Decode/hazard-side and writeback-side signals of the ALU issue scheduler.
interface alu_issue_sched_if
  import alu_issue_sched_pkg::*;
#(
  parameter int REG_W = DEFAULT_REG_W
);
  logic                issue_valid;
  logic [FUNCT3_W-1:0] issue_op;
  logic [REG_W-1:0]    issue_rd;
  logic                issue_ready;
  logic [REG_W-1:0]    src_rs1;
  logic [REG_W-1:0]    src_rs2;
  logic                src_hazard;
  logic                flush;
  logic                wb_valid;
  logic [REG_W-1:0]    wb_rd;
  logic                wb_is_mul;
  logic                busy;

  // decode / control side
  modport master (
    output issue_valid, issue_op, issue_rd, src_rs1, src_rs2, flush,
    input  issue_ready, src_hazard, wb_valid, wb_rd, wb_is_mul, busy
  );

  // scheduler side
  modport slave (
    input  issue_valid, issue_op, issue_rd, src_rs1, src_rs2, flush,
    output issue_ready, src_hazard, wb_valid, wb_rd, wb_is_mul, busy
  );
endinterface

// File: rtl/alu_issue_sched_wb_claim_shifter.sv
// Claim vector: one entry per future writeback cycle, shifting toward
// entry 1 every edge. A new claim is written at loadIdx after the shift.
// Array bit i holds slot i+1.
module alu_issue_sched_wb_claim_shifter #(
  parameter int DEPTH = 3,
  parameter int REG_W = 5,
  parameter int IDX_W = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        load,
  input  logic [IDX_W-1:0]            loadIdx,
  input  logic [REG_W-1:0]            loadRd,
  input  logic                        loadMul,
  output logic [DEPTH-1:0]            slotValid,
  output logic [DEPTH-1:0][REG_W-1:0] slotRd,
  output logic [DEPTH-1:0]            slotMul,
  output logic [DEPTH-1:0]            nextValid
);

  logic [DEPTH-1:0][REG_W-1:0] nextRd;
  logic [DEPTH-1:0]            nextMul;
  logic [DEPTH-1:0]            loadMask;

  // Shift by one slot, then overlay the new claim; clear wins over both.
  always_comb begin
    loadMask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      loadMask[i] = load && (loadIdx == IDX_W'(i + 1));
    end
    nextRd  = slotRd >> REG_W;
    nextMul = slotMul >> 1;
    for (int i = 0; i < DEPTH; i++) begin
      if (loadMask[i]) begin
        nextRd[i]  = loadRd;
        nextMul[i] = loadMul;
      end
    end
    nextValid = clear ? '0 : ((slotValid >> 1) | loadMask);
  end

  // Valid bits are control state and see the reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) slotValid <= '0;
    else     slotValid <= nextValid;
  end

  // Payload is only meaningful under its valid bit, so it is not reset.
  always_ff @(posedge clk) begin
    slotRd  <= nextRd;
    slotMul <= nextMul;
  end

endmodule

// File: rtl/alu_issue_sched.sv
// Execute-stage issue scheduler: arbitrates the shared ALU/MUL writeback
// port, blocks WAW reordering, answers RAW lookups for decode and drives
// the registered writeback tag/select.
module alu_issue_sched
  import alu_issue_sched_pkg::*;
#(
  parameter int MUL_LAT = DEFAULT_MUL_LAT,
  parameter int REG_W   = DEFAULT_REG_W
) (
  input  logic               clk,
  input  logic               rst,
  alu_issue_sched_if.slave   bus
);

  // A MUL claims the farthest slot, which after the shift is MUL_LAT-1;
  // slot MUL_LAT itself is therefore never held across an edge and needs
  // no storage. Slot 0 is the writeback register.
  localparam int DEPTH = MUL_LAT - 1;
  localparam int IDX_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;

  logic [DEPTH-1:0]            slotValid;
  logic [DEPTH-1:0][REG_W-1:0] slotRd;
  logic [DEPTH-1:0]            slotMul;
  logic [DEPTH-1:0]            nextValid;

  logic             isMul;
  int               lat;
  logic             claimBusy;
  logic             waw;
  logic             hazard;
  logic             ready;
  logic             accept;
  logic             wbValidNext;
  logic [REG_W-1:0] wbRdNext;
  logic             wbMulNext;
  logic             wbValid;
  logic [REG_W-1:0] wbRd;
  logic             wbMul;
  logic             busyReg;

  alu_issue_sched_wb_claim_shifter #(
    .DEPTH (DEPTH),
    .REG_W (REG_W),
    .IDX_W (IDX_W)
  ) claimShifter (
    .clk       (clk),
    .rst       (rst),
    .clear     (bus.flush),
    .load      (accept && isMul),
    .loadIdx   (IDX_W'(MUL_LAT - 1)),
    .loadRd    (bus.issue_rd),
    .loadMul   (1'b1),
    .slotValid (slotValid),
    .slotRd    (slotRd),
    .slotMul   (slotMul),
    .nextValid (nextValid)
  );

  // Port claim, WAW ordering and RAW lookup against the current slots.
  always_comb begin
    isMul     = (bus.issue_op == MUL_FUNCT3);
    lat       = opLatency(bus.issue_op, MUL_LAT);
    claimBusy = 1'b0;
    waw       = 1'b0;
    hazard    = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (slotValid[k-1] && (k == lat)) claimBusy = 1'b1;
      if (slotValid[k-1] && (k > lat) && (bus.issue_rd != '0) &&
          (slotRd[k-1] == bus.issue_rd)) waw = 1'b1;
      if (slotValid[k-1] && (slotRd[k-1] != '0) &&
          ((slotRd[k-1] == bus.src_rs1) || (slotRd[k-1] == bus.src_rs2))) hazard = 1'b1;
    end
    ready  = !bus.flush && !claimBusy && !waw;
    accept = bus.issue_valid && ready;
  end

  // Writeback source: a single-cycle op goes straight to the output
  // register, otherwise whatever is leaving slot 1.
  always_comb begin
    wbValidNext = slotValid[0];
    wbRdNext    = slotRd[0];
    wbMulNext   = slotMul[0] && slotValid[0];
    if (bus.flush) begin
      wbValidNext = 1'b0;
      wbMulNext   = 1'b0;
    end else if (accept && !isMul) begin
      wbValidNext = 1'b1;
      wbRdNext    = bus.issue_rd;
      wbMulNext   = 1'b0;
    end
  end

  // Output registers; busy covers the op being written back as well as
  // everything still queued behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbValid <= 1'b0;
      wbRd    <= '0;
      wbMul   <= 1'b0;
      busyReg <= 1'b0;
    end else begin
      wbValid <= wbValidNext;
      wbRd    <= wbRdNext;
      wbMul   <= wbMulNext;
      busyReg <= wbValidNext || (|nextValid);
    end
  end

  assign bus.issue_ready = ready;
  assign bus.src_hazard  = hazard;
  assign bus.wb_valid    = wbValid;
  assign bus.wb_rd       = wbRd;
  assign bus.wb_is_mul   = wbMul;
  assign bus.busy        = busyReg;

endmodule

// File: tb/tb_alu_issue_sched.sv
// Bench for alu_issue_sched: directed vector table, async reset sequence,
// and randomized traffic against an absolute-cycle writeback model.
module tb_alu_issue_sched;
  import alu_issue_sched_pkg::*;

  localparam int MUL_LAT = 4;
  localparam int REG_W   = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_sched_if #(.REG_W(REG_W)) bus();

  alu_issue_sched #(.MUL_LAT(MUL_LAT), .REG_W(REG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic setIn(input logic v, input logic [2:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic fl);
    bus.issue_valid = v;
    bus.issue_op    = op;
    bus.issue_rd    = rd;
    bus.src_rs1     = rs1;
    bus.src_rs2     = rs2;
    bus.flush       = fl;
  endtask

  typedef struct {
    logic       v;
    logic [2:0] op;
    logic [4:0] rd, rs1, rs2;
    logic       fl;
    logic       eReady, eHz, eWv;
    logic [4:0] eWr;
    logic       eWm, eBusy;
  } vecT;

  vecT vecs[$];

  task automatic addV(input logic v, input logic [2:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic fl,
                      input logic eR, input logic eH, input logic eWv,
                      input logic [4:0] eWr, input logic eWm, input logic eB);
    vecT t;
    t.v = v; t.op = op; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.fl = fl;
    t.eReady = eR; t.eHz = eH; t.eWv = eWv; t.eWr = eWr; t.eWm = eWm; t.eBusy = eB;
    vecs.push_back(t);
  endtask

  // Reference model: scheduled writebacks keyed by absolute cycle number,
  // value = {isMul, rd}.
  logic [5:0] pend [int];

  function automatic bit anyAtOrAfter(input int c);
    foreach (pend[k]) if (k >= c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit wawAfter(input int c, input logic [4:0] rd);
    if (rd == 0) return 1'b0;
    foreach (pend[k]) if (k > c && pend[k][4:0] == rd) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit rawHit(input int c, input logic [4:0] rs1, input logic [4:0] rs2);
    foreach (pend[k])
      if (k > c && pend[k][4:0] != 0 && (pend[k][4:0] == rs1 || pend[k][4:0] == rs2)) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int lat;
    int kill[$];
    logic v, fl;
    logic [2:0] op;
    logic [4:0] rd, rs1, rs2;
    logic eWv, eBusy, eReady, eHz;
    logic [5:0] eEnt;

    rst = 1'b1;
    setIn(0, 3'd0, 5'd0, 5'd3, 5'd0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wb_valid",  bus.wb_valid,   0);
    chk("reset_wb_rd",     bus.wb_rd,      0);
    chk("reset_wb_is_mul", bus.wb_is_mul,  0);
    chk("reset_busy",      bus.busy,       0);
    chk("reset_hazard",    bus.src_hazard, 0);
    chk("reset_ready",     bus.issue_ready, 1);
    rst = 1'b0;

    // ADD rd=3
    addV(1,3'd0,5'd3, 0,0,0, 1,0,0,5'd0,0,0);
    addV(0,3'd0,5'd0, 0,0,0, 1,0,1,5'd3,0,1);
    addV(0,3'd0,5'd0, 0,0,0, 1,0,0,5'd0,0,0);
    // undefined funct3 behaves as single-cycle
    addV(1,3'd7,5'd10,0,0,0, 1,0,0,5'd0,0,0);
    addV(0,3'd0,5'd0, 0,0,0, 1,0,1,5'd10,0,1);
    addV(0,3'd0,5'd0, 0,0,0, 1,0,0,5'd0,0,0);
    // writeback collision: MUL rd5, ADD rd6 refused in cycle 3
    addV(1,3'd4,5'd5, 0,0,0, 1,0,0,5'd0,0,0);
    addV(0,3'd0,5'd0, 0,0,0, 1,0,0,5'd0,0,1);
    addV(0,3'd0,5'd0, 0,0,0, 1,0,0,5'd0,0,1);
    addV(1,3'd0,5'd6, 0,0,0, 0,0,0,5'd0,0,1);
    addV(1,3'd0,5'd6, 0,0,0, 1,0,1,5'd5,1,1);
    addV(0,3'd0,5'd0, 0,0,0, 1,0,1,5'd6,0,1);
    addV(0,3'd0,5'd0, 0,0,0, 1,0,0,5'd0,0,0);
    // WAW: MUL rd7 then OR rd7
    addV(1,3'd4,5'd7, 0,0,0, 1,0,0,5'd0,0,0);
    addV(1,3'd3,5'd7, 0,0,0, 0,0,0,5'd0,0,1);
    addV(1,3'd3,5'd7, 0,0,0, 0,0,0,5'd0,0,1);
    addV(1,3'd3,5'd7, 0,0,0, 0,0,0,5'd0,0,1);
    addV(1,3'd3,5'd7, 0,0,0, 1,0,1,5'd7,1,1);
    addV(0,3'd0,5'd0, 0,0,0, 1,0,1,5'd7,0,1);
    addV(0,3'd0,5'd0, 0,0,0, 1,0,0,5'd0,0,0);
    // back-to-back MULs rd1..4
    addV(1,3'd4,5'd1, 0,0,0, 1,0,0,5'd0,0,0);
    addV(1,3'd4,5'd2, 0,0,0, 1,0,0,5'd0,0,1);
    addV(1,3'd4,5'd3, 0,0,0, 1,0,0,5'd0,0,1);
    addV(1,3'd4,5'd4, 0,0,0, 1,0,0,5'd0,0,1);
    addV(0,3'd0,5'd0, 0,0,0, 0,0,1,5'd1,1,1);
    addV(0,3'd0,5'd0, 0,0,0, 0,0,1,5'd2,1,1);
    addV(0,3'd0,5'd0, 0,0,0, 0,0,1,5'd3,1,1);
    addV(0,3'd0,5'd0, 0,0,0, 1,0,1,5'd4,1,1);
    addV(0,3'd0,5'd0, 0,0,0, 1,0,0,5'd0,0,0);
    // hazard and flush: MUL rd9, MUL rd0, flush
    addV(1,3'd4,5'd9, 0,0,0, 1,0,0,5'd0,0,0);
    addV(0,3'd0,5'd0, 9,0,0, 1,1,0,5'd0,0,1);
    addV(1,3'd4,5'd0, 0,9,0, 1,1,0,5'd0,0,1);
    addV(1,3'd0,5'd2, 5,0,1, 0,0,0,5'd0,0,1);
    addV(0,3'd0,5'd0, 0,0,0, 1,0,0,5'd0,0,0);
    addV(0,3'd0,5'd0, 0,0,0, 1,0,0,5'd0,0,0);
    addV(0,3'd0,5'd0, 0,0,0, 1,0,0,5'd0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      setIn(vecs[i].v, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].fl);
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i),  bus.issue_ready, vecs[i].eReady);
      chk($sformatf("vec%0d_hazard", i), bus.src_hazard,  vecs[i].eHz);
      chk($sformatf("vec%0d_wb_valid", i), bus.wb_valid,  vecs[i].eWv);
      if (vecs[i].eWv) begin
        chk($sformatf("vec%0d_wb_rd", i),     bus.wb_rd,     vecs[i].eWr);
        chk($sformatf("vec%0d_wb_is_mul", i), bus.wb_is_mul, vecs[i].eWm);
      end
      chk($sformatf("vec%0d_busy", i), bus.busy, vecs[i].eBusy);
      @(posedge clk);
      #1;
    end

    // async reset with two MULs in flight
    setIn(1, 3'd4, 5'd11, 0, 0, 0);
    @(posedge clk); #1;
    setIn(1, 3'd4, 5'd12, 0, 0, 0);
    @(posedge clk); #1;
    setIn(0, 3'd0, 5'd0, 5'd11, 5'd12, 0);
    #2;
    chk("prerst_busy",   bus.busy,       1);
    chk("prerst_hazard", bus.src_hazard, 1);
    rst = 1'b1;
    #1;
    chk("midrst_wb_valid", bus.wb_valid,   0);
    chk("midrst_busy",     bus.busy,       0);
    chk("midrst_hazard",   bus.src_hazard, 0);
    chk("midrst_ready",    bus.issue_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("postrst%0d_wb_valid", i), bus.wb_valid, 0);
      chk($sformatf("postrst%0d_busy", i),     bus.busy,     0);
    end
    @(posedge clk); #1;

    // randomized traffic against the model
    pend.delete();
    cyc = 0;
    for (int n = 0; n < 1500; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      op  = ($urandom_range(0, 7) < 3) ? 3'd4 : 3'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      fl  = ($urandom_range(0, 29) == 0);
      setIn(v, op, rd, rs1, rs2, fl);

      lat    = (op == 3'd4) ? MUL_LAT : 1;
      eWv    = pend.exists(cyc);
      eEnt   = eWv ? pend[cyc] : 6'd0;
      eBusy  = anyAtOrAfter(cyc);
      eReady = !fl && !pend.exists(cyc + lat) && !wawAfter(cyc + lat, rd);
      eHz    = rawHit(cyc, rs1, rs2);

      @(negedge clk);
      chk("rnd_ready",    bus.issue_ready, eReady);
      chk("rnd_hazard",   bus.src_hazard,  eHz);
      chk("rnd_wb_valid", bus.wb_valid,    eWv);
      if (eWv) begin
        chk("rnd_wb_rd",     bus.wb_rd,     eEnt[4:0]);
        chk("rnd_wb_is_mul", bus.wb_is_mul, eEnt[5]);
      end
      chk("rnd_busy", bus.busy, eBusy);

      if (pend.exists(cyc)) pend.delete(cyc);
      if (fl) begin
        kill.delete();
        foreach (pend[k]) if (k > cyc) kill.push_back(k);
        foreach (kill[j]) pend.delete(kill[j]);
      end else if (v && eReady) begin
        pend[cyc + lat] = {(op == 3'd4), rd};
      end

      @(posedge clk);
      #1;
      cyc++;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
